ex_macc_seq: RTL and testbench

- Execute-stage sequencer for the multi-cycle multiply-accumulate ops MADD, MADDU, MSUB and MSUBU.
- Sits inside EX. It drives the HI/LO write fields that EX hands to the EX/MEM pipeline register, and raises a stall request to the pipeline controller.
- Keeps its own cycle counter and product register, so the op state no longer round-trips through EX/MEM.
- Uses the same stall/flush vocabulary as the pipeline registers.

---
 rtl/ex_macc_seq_pkg.sv | 48 ++++
 rtl/ex_macc_seq_mult.sv | 23 ++
 rtl/ex_macc_seq.sv | 180 ++++++++++++++++++
 tb/tb_ex_macc_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_macc_seq_pkg.sv
// Shared definitions for the EX-stage multiply-accumulate sequencer:
// bus widths, ALU op codes, FSM state encoding and op-decode helpers.
// Build option: MACC_MUL_PIPE_EN splits the multiply over two cycles.
package ex_macc_seq_pkg;

  localparam int REG_W    = 32;
  localparam int DREG_W   = 64;
  localparam int ALUOP_W  = 8;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic FLUSH      = 1'b1;

  // ALU op codes seen by EX
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [ALUOP_W-1:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [ALUOP_W-1:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [ALUOP_W-1:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [ALUOP_W-1:0] EXE_MSUBU_OP = 8'b1010_1011;

`ifdef MACC_MUL_PIPE_EN
  localparam int MUL_LAT = 2;
  localparam int MUL_B_W = 16;
`else
  localparam int MUL_LAT = 1;
  localparam int MUL_B_W = 32;
`endif

  typedef enum logic [1:0] {
    MACC_IDLE = 2'd0,
    MACC_MUL  = 2'd1,
    MACC_ACC  = 2'd2
  } macc_state_e;

  function automatic logic is_macc(input logic [ALUOP_W-1:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

  function automatic logic is_signed_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MSUB_OP);
  endfunction

  function automatic logic is_sub_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

endpackage

// File: rtl/ex_macc_seq_mult.sv
// Combinational A_W x B_W multiplier with per-operand sign select.
// Operands are sign- or zero-extended to the product width so the
// result is exact modulo 2^P_W for any mix of signed/unsigned inputs.
module macc_mult #(
  parameter int A_W = 32,
  parameter int B_W = 32,
  parameter int P_W = 64
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  input  logic           sign_a_i,
  input  logic           sign_b_i,
  output logic [P_W-1:0] p_o
);

  logic [P_W-1:0] a_ext;
  logic [P_W-1:0] b_ext;

  assign a_ext = {{(P_W-A_W){sign_a_i & a_i[A_W-1]}}, a_i};
  assign b_ext = {{(P_W-B_W){sign_b_i & b_i[B_W-1]}}, b_i};
  assign p_o   = a_ext * b_ext;

endmodule

// File: rtl/ex_macc_seq.sv
// EX-stage sequencer for MADD/MADDU/MSUB/MSUBU. Holds its own product
// and cycle counter, stalls the pipe while the product is built, then
// writes {HI,LO} +/- product in the ACC cycle.
// Build option: MACC_MUL_PIPE_EN -> two 32x16 partial products (MUL_LAT=2).
module ex_macc_seq
  import ex_macc_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [REG_W-1:0]   opa_i,
  input  logic [REG_W-1:0]   opb_i,
  input  logic [REG_W-1:0]   hi_i,
  input  logic [REG_W-1:0]   lo_i,
  input  logic               flush,
  input  logic               hold_i,
  output logic               stallreq_o,
  output logic               whilo_o,
  output logic [REG_W-1:0]   hi_o,
  output logic [REG_W-1:0]   lo_o,
  output logic               busy_o
);

  macc_state_e         state_q, state_d;
  logic [DREG_W-1:0]   product_q, product_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                sub_q, sub_d;

  logic [REG_W-1:0]    mul_a;
  logic [MUL_B_W-1:0]  mul_b;
  logic                mul_sign_a;
  logic                mul_sign_b;
  logic [DREG_W-1:0]   mul_p;
  logic [DREG_W-1:0]   acc_res;

`ifdef MACC_MUL_PIPE_EN
  logic [REG_W-1:0]    opa_q, opa_d;
  logic [15:0]         opb_hi_q, opb_hi_d;
  logic                sgn_q, sgn_d;

  // Low half of opb (unsigned) at issue, high half (signed per op) in MUL
  always_comb begin
    if (state_q == MACC_MUL) begin
      mul_a      = opa_q;
      mul_b      = opb_hi_q;
      mul_sign_a = sgn_q;
      mul_sign_b = sgn_q;
    end else begin
      mul_a      = opa_i;
      mul_b      = opb_i[15:0];
      mul_sign_a = is_signed_op(aluop_i);
      mul_sign_b = 1'b0;
    end
  end
`else
  assign mul_a      = opa_i;
  assign mul_b      = opb_i;
  assign mul_sign_a = is_signed_op(aluop_i);
  assign mul_sign_b = is_signed_op(aluop_i);
`endif

  macc_mult #(
    .A_W (REG_W),
    .B_W (MUL_B_W),
    .P_W (DREG_W)
  ) u_mult (
    .a_i      (mul_a),
    .b_i      (mul_b),
    .sign_a_i (mul_sign_a),
    .sign_b_i (mul_sign_b),
    .p_o      (mul_p)
  );

  // Modulo-2^64 accumulate; carry/borrow out is dropped
  assign acc_res = sub_q ? ({hi_i, lo_i} - product_q) : ({hi_i, lo_i} + product_q);

  // Next-state logic; flush overrides hold and start
  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
`ifdef MACC_MUL_PIPE_EN
    opa_d     = opa_q;
    opb_hi_d  = opb_hi_q;
    sgn_d     = sgn_q;
`endif
    if (flush == FLUSH) begin
      state_d   = MACC_IDLE;
      cnt_d     = 2'd0;
      product_d = '0;
    end else begin
      case (state_q)
        MACC_IDLE: begin
          if (is_macc(aluop_i)) begin
            product_d = mul_p;
            sub_d     = is_sub_op(aluop_i);
            cnt_d     = 2'd1;
`ifdef MACC_MUL_PIPE_EN
            opa_d     = opa_i;
            opb_hi_d  = opb_i[31:16];
            sgn_d     = is_signed_op(aluop_i);
            state_d   = MACC_MUL;
`else
            state_d   = MACC_ACC;
`endif
          end
        end
        MACC_MUL: begin
`ifdef MACC_MUL_PIPE_EN
          product_d = product_q + (mul_p << 16);
          cnt_d     = cnt_q + 2'd1;
          if (cnt_d == 2'(MUL_LAT)) begin
            state_d = MACC_ACC;
          end
`else
          state_d = MACC_IDLE;
`endif
        end
        MACC_ACC: begin
          if (!hold_i) begin
            state_d = MACC_IDLE;
            cnt_d   = 2'd0;
          end
        end
        default: begin
          state_d = MACC_IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= MACC_IDLE;
      product_q <= '0;
      cnt_q     <= 2'd0;
      sub_q     <= 1'b0;
`ifdef MACC_MUL_PIPE_EN
      opa_q     <= '0;
      opb_hi_q  <= '0;
      sgn_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
`ifdef MACC_MUL_PIPE_EN
      opa_q     <= opa_d;
      opb_hi_q  <= opb_hi_d;
      sgn_q     <= sgn_d;
`endif
    end
  end

  // Stall/write outputs; silenced during reset and flush cycles
  always_comb begin
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    if ((rst != RST_ENABLE) && (flush != FLUSH)) begin
      case (state_q)
        MACC_IDLE: stallreq_o = is_macc(aluop_i);
        MACC_MUL:  stallreq_o = 1'b1;
        MACC_ACC: begin
          whilo_o      = 1'b1;
          {hi_o, lo_o} = acc_res;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q != MACC_IDLE);

endmodule

// File: tb/tb_ex_macc_seq.sv
// Directed bench for ex_macc_seq: result/latency vectors, hold, flush, reset.
module tb_ex_macc_seq;
  import ex_macc_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [ALUOP_W-1:0] aluop_i;
  logic [31:0]        opa_i, opb_i, hi_i, lo_i;
  logic               flush, hold_i;
  logic               stallreq_o, whilo_o, busy_o;
  logic [31:0]        hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  ex_macc_seq dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .flush      (flush),
    .hold_i     (hold_i),
    .stallreq_o (stallreq_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue an op and advance to the first ACC cycle (returns at its negedge)
  task automatic issue_to_acc(input string tag, input logic [7:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hi, input logic [31:0] lo,
                              input logic hold);
    int cyc;
    @(posedge clk); #1;
    aluop_i = op; opa_i = a; opb_i = b; hi_i = hi; lo_i = lo;
    hold_i = hold; flush = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (stallreq_o && cyc < 8) begin
      check({tag, "_nowr_stall"}, 64'(whilo_o), 64'd0);
      cyc++;
      @(negedge clk);
    end
    check({tag, "_stall_cycles"}, 64'(cyc), 64'(MUL_LAT));
  endtask

  // Full transaction: check the ACC write, then drop back to IDLE
  task automatic run_op(input string tag, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo,
                        input logic [63:0] exp);
    issue_to_acc(tag, op, a, b, hi, lo, 1'b0);
    check({tag, "_whilo"}, 64'(whilo_o), 64'd1);
    check({tag, "_hilo"}, {hi_o, lo_o}, exp);
    $display("op %s a=%h b=%h hilo_in=%h_%h -> hi=%h lo=%h", tag, a, b, hi, lo, hi_o, lo_o);
    @(posedge clk); #1;
    aluop_i = EXE_NOP_OP;
    @(negedge clk);
    check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_idle_stall"}, 64'(stallreq_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1; aluop_i = EXE_NOP_OP; opa_i = '0; opb_i = '0;
    hi_i = '0; lo_i = '0; flush = 1'b0; hold_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 aluop_i = EXE_MADD_OP;
    @(negedge clk);
    check("rst_stall", 64'(stallreq_o), 64'd0);
    check("rst_whilo", 64'(whilo_o), 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; aluop_i = EXE_NOP_OP;
    @(negedge clk);
    check("nop_stall", 64'(stallreq_o), 64'd0);
    check("nop_whilo", 64'(whilo_o), 64'd0);
    $display("reset done");

    // Result vectors
    run_op("maddu_small", EXE_MADDU_OP, 32'd3, 32'd5, 32'h0, 32'h10, 64'h0000_0000_0000_001F);
    run_op("madd_neg",    EXE_MADD_OP,  32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("msubu_wrap",  EXE_MSUBU_OP, 32'd2, 32'd3, 32'h0, 32'h5, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("msub_neg",    EXE_MSUB_OP,  32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 64'h0000_0000_0000_0006);
    run_op("maddu_max",   EXE_MADDU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 64'hFFFF_FFFE_0000_0001);
    run_op("maddu_2p32",  EXE_MADDU_OP, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 64'h0000_0001_0000_0000);
    run_op("madd_split",  EXE_MADD_OP,  32'h1234_5678, 32'hFFFF_8000, 32'h1, 32'h0, 64'hFFFF_F6E6_D4C4_0000);
    run_op("maddu_carry", EXE_MADDU_OP, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000);
    run_op("msubu_hi",    EXE_MSUBU_OP, 32'h0000_0010, 32'h1000_0000, 32'h5, 32'h0, 64'h0000_0004_0000_0000);

    // Hold in ACC: same result for 3 held cycles plus the release cycle
    issue_to_acc("hold", EXE_MADD_OP, 32'd7, 32'd6, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      check("hold_whilo", 64'(whilo_o), 64'd1);
      check("hold_hilo", {hi_o, lo_o}, 64'd42);
      check("hold_stall", 64'(stallreq_o), 64'd0);
    end
    @(posedge clk); #1;
    hold_i = 1'b0;
    @(negedge clk);
    check("hold_rel_whilo", 64'(whilo_o), 64'd1);
    check("hold_rel_hilo", {hi_o, lo_o}, 64'd42);
    @(posedge clk); #1;
    aluop_i = EXE_NOP_OP;
    @(negedge clk);
    check("hold_after_busy", 64'(busy_o), 64'd0);
    check("hold_after_stall", 64'(stallreq_o), 64'd0);
    $display("op hold done");

    // Flush in ACC
    issue_to_acc("flush_acc", EXE_MADDU_OP, 32'd9, 32'd9, 32'h0, 32'h0, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_acc_whilo", 64'(whilo_o), 64'd0);
    check("flush_acc_stall", 64'(stallreq_o), 64'd0);
    check("flush_acc_hilo", {hi_o, lo_o}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; aluop_i = EXE_NOP_OP;
    @(negedge clk);
    check("flush_acc_busy", 64'(busy_o), 64'd0);
    $display("op flush_acc done");
    run_op("after_flush", EXE_MADDU_OP, 32'd1, 32'd1, 32'h0, 32'h0, 64'd1);

    // Flush together with start: no stall, nothing issued
    @(posedge clk); #1;
    aluop_i = EXE_MADD_OP; opa_i = 32'd4; opb_i = 32'd4; flush = 1'b1;
    @(negedge clk);
    check("flush_start_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; aluop_i = EXE_NOP_OP;
    @(negedge clk);
    check("flush_start_busy", 64'(busy_o), 64'd0);
    $display("op flush_start done");

`ifdef MACC_MUL_PIPE_EN
    // Flush in MUL
    @(posedge clk); #1;
    aluop_i = EXE_MADDU_OP; opa_i = 32'd5; opb_i = 32'd5; hi_i = '0; lo_i = '0;
    @(posedge clk); #1;
    check("flush_mul_busy_pre", 64'(busy_o), 64'd1);
    flush = 1'b1; aluop_i = EXE_NOP_OP;
    #1;
    check("flush_mul_stall", 64'(stallreq_o), 64'd0);
    check("flush_mul_whilo", 64'(whilo_o), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_mul_busy", 64'(busy_o), 64'd0);
    $display("op flush_mul done");
`endif

    // Reset mid-op in ACC
    issue_to_acc("rst_acc", EXE_MADD_OP, 32'd3, 32'd3, 32'h0, 32'h0, 1'b1);
    check("rst_acc_pre_whilo", 64'(whilo_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_acc_whilo", 64'(whilo_o), 64'd0);
    check("rst_acc_busy", 64'(busy_o), 64'd0);
    check("rst_acc_hilo", {hi_o, lo_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; hold_i = 1'b0; aluop_i = EXE_NOP_OP;
    @(negedge clk);
    check("rst_acc_post_whilo", 64'(whilo_o), 64'd0);
    check("rst_acc_post_stall", 64'(stallreq_o), 64'd0);
    check("rst_acc_post_busy", 64'(busy_o), 64'd0);
    $display("op rst_acc done");

    run_op("after_rst", EXE_MADD_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h2, 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
